msg_segmenter: RTL and testbench

//  Front-end gearbox of the LDPC encoder. It takes the information stream as IN_W-bit words and

---
 rtl/msg_segmenter.sv | 185 ++++++++++++++++++
 tb/tb_msg_segmenter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_segmenter.sv
// Repacks an IN_W-bit information stream into Zc-bit lifted message blocks, one per base-graph column.
// Optional zero padding after an early in_last is enabled with `define MSG_SEG_ZERO_PAD_EN.
package LDPC_pkg;
  localparam int MAX_ZC = 384;
  typedef enum logic {BG1 = 1'b0, BG2 = 1'b1} BG_Type;
endpackage

module msg_segmenter #(
  parameter int IN_W   = 32,
  parameter int MAX_ZC = LDPC_pkg::MAX_ZC
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  LDPC_pkg::BG_Type       bg_in,
  input  logic [8:0]             zc_in,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
`ifdef MSG_SEG_ZERO_PAD_EN
  input  logic                   in_last,
`endif
  output logic                   in_ready,
  output logic [MAX_ZC-1:0]      segmented_msg_block,
  output logic                   new_seg_msg_block,
  output logic [4:0]             current_col,
  output logic                   blk_done,
  output logic                   cfg_err,
  output logic                   busy
);
  localparam int ACC_W  = MAX_ZC + IN_W;
  localparam int FILL_W = $clog2(MAX_ZC + IN_W + 1);
  localparam logic [9:0]        MAX_ZC_V = 10'(MAX_ZC);
  localparam logic [MAX_ZC-1:0] ONES     = '1;

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_e;
  state_e state_q, state_d;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [4:0]        col_q, col_d;
  LDPC_pkg::BG_Type  bg_q, bg_d;
  logic [8:0]        zc_q, zc_d;
  logic              last_q, last_d;
  logic [MAX_ZC-1:0] blk_q, blk_d;
  logic [4:0]        ccol_q, ccol_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              zc_legal, accept, last_set, last_col;
  logic [4:0]        kb_m1;
  logic [FILL_W-1:0] zc_f, fill_acc, fill_res;
  logic [MAX_ZC-1:0] zc_mask;

  assign zc_legal = (zc_in >= 9'd2) && ({1'b0, zc_in} <= MAX_ZC_V);
  assign kb_m1    = (bg_q == LDPC_pkg::BG1) ? 5'd21 : 5'd9;
  assign last_col = (col_q == kb_m1);
  assign zc_f     = FILL_W'(zc_q);
  assign zc_mask  = ONES >> (MAX_ZC_V - {1'b0, zc_q});
  assign in_ready = (state_q == FILL) && (fill_q < zc_f) && !last_q;
  assign accept   = in_ready && in_valid;
  assign fill_acc = fill_q + (accept ? FILL_W'(IN_W) : '0);
  // A padded final column may hold fewer than zc real bits, so the residual floors at zero.
  assign fill_res = (fill_q >= zc_f) ? fill_q - zc_f : '0;

`ifdef MSG_SEG_ZERO_PAD_EN
  assign last_set = accept && in_last;
`else
  assign last_set = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && zc_legal) state_d = FILL;
      FILL: if (fill_acc >= zc_f || last_set) state_d = EMIT;
      EMIT: begin
        if (last_col)                          state_d = IDLE;
        else if (fill_res < zc_f && !last_q)   state_d = FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    fill_d   = fill_q;
    col_d    = col_q;
    bg_d     = bg_q;
    zc_d     = zc_q;
    last_d   = last_q;
    blk_d    = blk_q;
    ccol_d   = ccol_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        if (zc_legal) begin
          bg_d   = bg_in;
          zc_d   = zc_in;
          col_d  = '0;
          acc_d  = '0;
          fill_d = '0;
          last_d = 1'b0;
          busy_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      FILL: begin
        if (accept) begin
          acc_d  = acc_q | (ACC_W'(in_data) << fill_q);
          fill_d = fill_acc;
        end
        if (last_set) last_d = 1'b1;
      end
      EMIT: begin
        blk_d    = acc_q[MAX_ZC-1:0] & zc_mask;
        ccol_d   = col_q;
        strobe_d = 1'b1;
        if (last_col) begin
          // Bits left over past the final column belong to no block and are dropped.
          acc_d  = '0;
          fill_d = '0;
          col_d  = '0;
          last_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          acc_d  = acc_q >> zc_q;
          fill_d = fill_res;
          col_d  = col_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      fill_q   <= '0;
      col_q    <= '0;
      bg_q     <= LDPC_pkg::BG1;
      zc_q     <= '0;
      last_q   <= 1'b0;
      blk_q    <= '0;
      ccol_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling the pre-edge values.
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      col_q    <= col_d;
      bg_q     <= bg_d;
      zc_q     <= zc_d;
      last_q   <= last_d;
      blk_q    <= blk_d;
      ccol_q   <= ccol_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign segmented_msg_block = blk_q;
  assign new_seg_msg_block   = strobe_q;
  assign current_col         = ccol_q;
  assign blk_done            = done_q;
  assign cfg_err             = err_q;
  assign busy                = busy_q;
endmodule

// File: tb/tb_msg_segmenter.sv
// Scoreboard bench for msg_segmenter: expected blocks are derived from the generated word stream
// when a code block is set up and compared on every strobe. Define MSG_SEG_ZERO_PAD_EN to add the padding case.
module tb_msg_segmenter;
  localparam int IN_W   = 32;
  localparam int MAX_ZC = 384;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  LDPC_pkg::BG_Type  bg_in = LDPC_pkg::BG1;
  logic [8:0]        zc_in = '0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
`ifdef MSG_SEG_ZERO_PAD_EN
  logic              in_last = 1'b0;
`endif
  logic              in_ready, new_seg_msg_block, blk_done, cfg_err, busy;
  logic [MAX_ZC-1:0] segmented_msg_block;
  logic [4:0]        current_col;

  typedef struct {
    logic [4:0]        col;
    logic [MAX_ZC-1:0] blk;
    logic              done;
  } exp_t;

  exp_t            sb[$];
  logic [IN_W-1:0] words[$];
  int              errors = 0;
  int              checks = 0;

  always #5 clk = ~clk;

  msg_segmenter #(.IN_W(IN_W), .MAX_ZC(MAX_ZC)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .bg_in               (bg_in),
    .zc_in               (zc_in),
    .in_data             (in_data),
    .in_valid            (in_valid),
`ifdef MSG_SEG_ZERO_PAD_EN
    .in_last             (in_last),
`endif
    .in_ready            (in_ready),
    .segmented_msg_block (segmented_msg_block),
    .new_seg_msg_block   (new_seg_msg_block),
    .current_col         (current_col),
    .blk_done            (blk_done),
    .cfg_err             (cfg_err),
    .busy                (busy)
  );

  task automatic check(input string tag, input logic [MAX_ZC-1:0] obs, input logic [MAX_ZC-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected block.
  always @(negedge clk) begin
    if (reset_n && new_seg_msg_block === 1'b1) begin
      check("strobe_expected", MAX_ZC'(sb.size() != 0), MAX_ZC'(1));
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("col", MAX_ZC'(current_col), MAX_ZC'(e.col));
        check("block", segmented_msg_block, e.blk);
        check("blk_done", MAX_ZC'(blk_done), MAX_ZC'(e.done));
      end
    end
  end

  // Builds the word stream (words past pad_from are zero) and pushes expected columns 0..ncols-1.
  task automatic prep(input LDPC_pkg::BG_Type bg, input int zc, input bit incr,
                      input int pad_from, input int ncols);
    int kb, nw;
    kb = (bg == LDPC_pkg::BG1) ? 22 : 10;
    nw = (kb * zc + IN_W - 1) / IN_W;
    words.delete();
    for (int i = 0; i < nw; i++) begin
      if (i >= pad_from) words.push_back('0);
      else if (incr)     words.push_back(IN_W'(i + 1));
      else               words.push_back($urandom);
    end
    for (int c = 0; c < ncols; c++) begin
      exp_t e;
      e.blk  = '0;
      e.col  = 5'(c);
      e.done = (c == kb - 1);
      for (int b = 0; b < zc; b++) begin
        int k;
        logic [IN_W-1:0] w;
        k = c * zc + b;
        w = words[k / IN_W];
        e.blk[b] = w[k % IN_W];
      end
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input LDPC_pkg::BG_Type bg, input int zc);
    start = 1'b1;
    bg_in = bg;
    zc_in = 9'(zc);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds nfeed words; for zc >= IN_W it also checks the one-cycle strobe latency after a completing word.
  task automatic feed(input int nfeed, input int zc, input int last_idx);
    int i, budget;
    bit took, pend;
    i = 0; budget = 0; pend = 1'b0;
    while (i < nfeed && budget < 2000) begin
      in_valid = 1'b1;
      in_data  = words[i];
`ifdef MSG_SEG_ZERO_PAD_EN
      in_last  = (i == last_idx);
`endif
      took = in_ready;
      @(negedge clk);
      budget++;
      if (pend) begin
        check("strobe_latency", MAX_ZC'(new_seg_msg_block), MAX_ZC'(1));
        pend = 1'b0;
      end
      if (took) begin
        i++;
        if (zc >= IN_W && last_idx < 0 && (i * IN_W) / zc > ((i - 1) * IN_W) / zc) begin
          check("ready_low_in_emit", MAX_ZC'(in_ready), MAX_ZC'(0));
          pend = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
`ifdef MSG_SEG_ZERO_PAD_EN
    in_last  = 1'b0;
`endif
    check("feed_done_in_budget", MAX_ZC'(i), MAX_ZC'(nfeed));
    if (pend) begin
      @(negedge clk);
      check("strobe_latency", MAX_ZC'(new_seg_msg_block), MAX_ZC'(1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("all_strobes_seen", MAX_ZC'(sb.size()), '0);
  endtask

  task automatic run_block(input LDPC_pkg::BG_Type bg, input int zc, input bit incr);
    int kb;
    kb = (bg == LDPC_pkg::BG1) ? 22 : 10;
    prep(bg, zc, incr, 1 << 30, kb);
    do_start(bg, zc);
    check("busy_after_start", MAX_ZC'(busy), MAX_ZC'(1));
    feed(words.size(), zc, -1);
    drain();
    @(negedge clk);
    check("busy_after_done", MAX_ZC'(busy), '0);
    check("done_is_pulse", MAX_ZC'(blk_done), '0);
  endtask

  task automatic bad_start(input int zc, input string tag);
    do_start(LDPC_pkg::BG2, zc);
    check({tag, "_cfg_err"}, MAX_ZC'(cfg_err), MAX_ZC'(1));
    check({tag, "_busy"}, MAX_ZC'(busy), '0);
    @(negedge clk);
    check({tag, "_cfg_err_pulse"}, MAX_ZC'(cfg_err), '0);
    check({tag, "_in_ready"}, MAX_ZC'(in_ready), '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_block"}, segmented_msg_block, '0);
    check({tag, "_strobe"}, MAX_ZC'(new_seg_msg_block), '0);
    check({tag, "_col"}, MAX_ZC'(current_col), '0);
    check({tag, "_done"}, MAX_ZC'(blk_done), '0);
    check({tag, "_cfg_err"}, MAX_ZC'(cfg_err), '0);
    check({tag, "_busy"}, MAX_ZC'(busy), '0);
    check({tag, "_in_ready"}, MAX_ZC'(in_ready), '0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // BG2, zc=64: two incrementing words per column.
    run_block(LDPC_pkg::BG2, 64, 1'b1);

    // BG1, zc=384: twelve words per column, then no further acceptance.
    run_block(LDPC_pkg::BG1, 384, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hdead_beef;
    @(negedge clk);
    check("idle_not_ready", MAX_ZC'(in_ready), '0);
    in_valid = 1'b0;

    // BG2, zc=52: residual bits carry over between columns.
    run_block(LDPC_pkg::BG2, 52, 1'b0);

    // BG2, zc=8: four back-to-back columns per word.
    run_block(LDPC_pkg::BG2, 8, 1'b0);

    // Illegal lifting sizes are rejected.
    bad_start(0, "zc0");
    bad_start(1, "zc1");
    bad_start(400, "zc400");

    // A start while busy is ignored; the block keeps its original configuration.
    prep(LDPC_pkg::BG2, 64, 1'b0, 1 << 30, 10);
    do_start(LDPC_pkg::BG2, 64);
    do_start(LDPC_pkg::BG1, 8);
    check("busy_start_no_cfg_err", MAX_ZC'(cfg_err), '0);
    feed(words.size(), 64, -1);
    drain();
    @(negedge clk);
    check("busy_start_busy_low", MAX_ZC'(busy), '0);

    // Reset after column 5 clears everything at once; a fresh block then runs normally.
    prep(LDPC_pkg::BG2, 64, 1'b0, 1 << 30, 6);
    do_start(LDPC_pkg::BG2, 64);
    feed(12, 64, -1);
    drain();
    check("mid_busy", MAX_ZC'(busy), MAX_ZC'(1));
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_block(LDPC_pkg::BG2, 64, 1'b1);

`ifdef MSG_SEG_ZERO_PAD_EN
    // in_last on the third word: column 1 is half padded, columns 2..9 are all zero.
    prep(LDPC_pkg::BG2, 64, 1'b1, 3, 10);
    do_start(LDPC_pkg::BG2, 64);
    feed(3, 64, 2);
    check("pad_ready_low", MAX_ZC'(in_ready), '0);
    drain();
    @(negedge clk);
    check("pad_busy_low", MAX_ZC'(busy), '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
